// File: rtl/task3_circle.sv
`default_nettype none
// ============================================================================
//  Module      : task3_circle (+ vga_adapter)
//  Description : Circle-drawing stage of the DE1-SoC VGA design. Clears the
//                160x120 frame buffer to black, one pixel per clock, then
//                draws a green circle of radius 40 centred at (80,60) with the
//                integer midpoint circle algorithm, one octant pixel per
//                clock. Pixels go to vga_adapter and are also exported.
//  Ports       : CLOCK_50          system clock
//                KEY[3]            resetn, asynchronous active-low
//                SW, KEY[2:0]      unused
//                LEDR[0]           drawing finished
//                HEX0..HEX5        blanked (7'h7F)
//                VGA_R/G/B/HS/VS/CLK  video out from vga_adapter
//                VGA_X/Y/COLOUR/PLOT  registered plot bus
//  Revision    : 1.0  initial release
// ============================================================================
module task3_circle (
   input  logic       CLOCK_50,
   input  logic [3:0] KEY,
   input  logic [9:0] SW,
   output logic [9:0] LEDR,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_CLK,
   output logic [7:0] VGA_X,
   output logic [6:0] VGA_Y,
   output logic [2:0] VGA_COLOUR,
   output logic       VGA_PLOT
);

   localparam logic [2:0] c_ST_FILL      = 3'd0;
   localparam logic [2:0] c_ST_CIRC_INIT = 3'd1;
   localparam logic [2:0] c_ST_CIRC_PLOT = 3'd2;
   localparam logic [2:0] c_ST_CIRC_STEP = 3'd3;
   localparam logic [2:0] c_ST_DONE      = 3'd4;

   localparam logic signed [9:0]  c_CENTRE_X = 10'sd80;
   localparam logic signed [9:0]  c_CENTRE_Y = 10'sd60;
   localparam logic signed [9:0]  c_RADIUS   = 10'sd40;
   localparam logic signed [9:0]  c_X_MAX    = 10'sd159;
   localparam logic signed [9:0]  c_Y_MAX    = 10'sd119;
   localparam logic signed [11:0] c_CRIT0    = -12'sd39;   // 1 - radius
   localparam logic [2:0]         c_GREEN    = 3'b010;

   logic rst_n;
   assign rst_n = KEY[3];

   logic unused_inputs;
   assign unused_inputs = ^{SW, KEY[2:0]};

   // State and datapath registers
   logic [2:0]         state_q, state_d;
   logic [7:0]         fx_q, fx_d;       // fill scan column
   logic [6:0]         fy_q, fy_d;       // fill scan row
   logic signed [9:0]  ox_q, ox_d;
   logic signed [9:0]  oy_q, oy_d;
   logic signed [11:0] crit_q, crit_d;
   logic [2:0]         oct_q, oct_d;
   logic [7:0]         x_q, x_d;
   logic [6:0]         y_q, y_d;
   logic [2:0]         col_q, col_d;
   logic               plot_q, plot_d;

   // Candidate pixel for the current octant, kept at full signed width so the
   // clip test sees out-of-range values before truncation.
   logic signed [9:0]  cand_x, cand_y;
   logic               cand_in_range;

   always_comb begin
      cand_x = c_CENTRE_X;
      cand_y = c_CENTRE_Y;
      case (oct_q)
         3'd0: begin cand_x = c_CENTRE_X + ox_q; cand_y = c_CENTRE_Y + oy_q; end
         3'd1: begin cand_x = c_CENTRE_X + oy_q; cand_y = c_CENTRE_Y + ox_q; end
         3'd2: begin cand_x = c_CENTRE_X - ox_q; cand_y = c_CENTRE_Y + oy_q; end
         3'd3: begin cand_x = c_CENTRE_X - oy_q; cand_y = c_CENTRE_Y + ox_q; end
         3'd4: begin cand_x = c_CENTRE_X - ox_q; cand_y = c_CENTRE_Y - oy_q; end
         3'd5: begin cand_x = c_CENTRE_X - oy_q; cand_y = c_CENTRE_Y - ox_q; end
         3'd6: begin cand_x = c_CENTRE_X + ox_q; cand_y = c_CENTRE_Y - oy_q; end
         default: begin cand_x = c_CENTRE_X + oy_q; cand_y = c_CENTRE_Y - ox_q; end
      endcase
      cand_in_range = (cand_x >= 10'sd0) && (cand_x <= c_X_MAX) &&
                      (cand_y >= 10'sd0) && (cand_y <= c_Y_MAX);
   end

   // Step arithmetic: oy is incremented first, and the decision variable
   // update uses the already-updated offsets.
   logic signed [9:0]  oy_nxt, ox_nxt;
   logic signed [11:0] oy_nxt_ext, ox_nxt_ext, crit_nxt;

   always_comb begin
      oy_nxt     = oy_q + 10'sd1;
      ox_nxt     = ox_q;
      oy_nxt_ext = {{2{oy_nxt[9]}}, oy_nxt};
      ox_nxt_ext = {{2{ox_q[9]}}, ox_q};
      crit_nxt   = crit_q + (oy_nxt_ext <<< 1) + 12'sd1;
      if (crit_q > 12'sd0) begin
         ox_nxt     = ox_q - 10'sd1;
         ox_nxt_ext = {{2{ox_nxt[9]}}, ox_nxt};
         crit_nxt   = crit_q + ((oy_nxt_ext - ox_nxt_ext) <<< 1) + 12'sd1;
      end
   end

   always_comb begin
      state_d = state_q;
      fx_d    = fx_q;
      fy_d    = fy_q;
      ox_d    = ox_q;
      oy_d    = oy_q;
      crit_d  = crit_q;
      oct_d   = oct_q;
      x_d     = x_q;
      y_d     = y_q;
      col_d   = col_q;
      plot_d  = 1'b0;
      case (state_q)
         c_ST_FILL: begin
            x_d    = fx_q;
            y_d    = fy_q;
            col_d  = 3'b000;
            plot_d = 1'b1;
            if (fy_q == 7'd119) begin
               fy_d = 7'd0;
               if (fx_q == 8'd159) begin
                  fx_d    = 8'd0;
                  state_d = c_ST_CIRC_INIT;
               end else begin
                  fx_d = fx_q + 8'd1;
               end
            end else begin
               fy_d = fy_q + 7'd1;
            end
         end
         c_ST_CIRC_INIT: begin
            ox_d    = c_RADIUS;
            oy_d    = 10'sd0;
            crit_d  = c_CRIT0;
            oct_d   = 3'd0;
            state_d = c_ST_CIRC_PLOT;
         end
         c_ST_CIRC_PLOT: begin
            x_d    = cand_x[7:0];
            y_d    = cand_y[6:0];
            col_d  = c_GREEN;
            plot_d = cand_in_range;
            oct_d  = oct_q + 3'd1;
            if (oct_q == 3'd7) begin
               state_d = c_ST_CIRC_STEP;
            end
         end
         c_ST_CIRC_STEP: begin
            oy_d   = oy_nxt;
            ox_d   = ox_nxt;
            crit_d = crit_nxt;
            oct_d  = 3'd0;
            if (oy_nxt <= ox_nxt) begin
               state_d = c_ST_CIRC_PLOT;
            end else begin
               state_d = c_ST_DONE;
            end
         end
         c_ST_DONE: begin
            state_d = c_ST_DONE;
         end
         default: begin
            state_d = c_ST_FILL;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= c_ST_FILL;
         fx_q    <= 8'd0;
         fy_q    <= 7'd0;
         ox_q    <= 10'sd0;
         oy_q    <= 10'sd0;
         crit_q  <= 12'sd0;
         oct_q   <= 3'd0;
         x_q     <= 8'd0;
         y_q     <= 7'd0;
         col_q   <= 3'd0;
         plot_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fx_q    <= fx_d;
         fy_q    <= fy_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         crit_q  <= crit_d;
         oct_q   <= oct_d;
         x_q     <= x_d;
         y_q     <= y_d;
         col_q   <= col_d;
         plot_q  <= plot_d;
      end
   end

   assign VGA_X      = x_q;
   assign VGA_Y      = y_q;
   assign VGA_COLOUR = col_q;
   assign VGA_PLOT   = plot_q;
   assign LEDR       = {9'd0, (state_q == c_ST_DONE)};
   assign HEX0       = 7'h7F;
   assign HEX1       = 7'h7F;
   assign HEX2       = 7'h7F;
   assign HEX3       = 7'h7F;
   assign HEX4       = 7'h7F;
   assign HEX5       = 7'h7F;

   vga_adapter u_vga (
      .resetn  (rst_n),
      .clock   (CLOCK_50),
      .colour  (col_q),
      .x       (x_q),
      .y       (y_q),
      .plot    (plot_q),
      .VGA_R   (VGA_R),
      .VGA_G   (VGA_G),
      .VGA_B   (VGA_B),
      .VGA_HS  (VGA_HS),
      .VGA_VS  (VGA_VS),
      .VGA_CLK (VGA_CLK)
   );

endmodule

// ============================================================================
//  Module      : vga_adapter
//  Description : 160x120x3 frame buffer with a 640x480@60 scan-out. Each
//                buffer pixel is shown as a 4x4 block. One write per clock
//                when plot is high; the pixel clock is CLOCK_50 / 2.
//  Ports       : resetn, clock        async active-low reset, system clock
//                colour, x, y, plot   write port (out-of-range writes dropped)
//                VGA_*                video timing and colour
//  Revision    : 1.0  initial release
// ============================================================================
module vga_adapter (
   input  logic       resetn,
   input  logic       clock,
   input  logic [2:0] colour,
   input  logic [7:0] x,
   input  logic [6:0] y,
   input  logic       plot,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_CLK
);

   localparam logic [9:0] c_H_VIS   = 10'd640;
   localparam logic [9:0] c_H_SYNC0 = 10'd656;
   localparam logic [9:0] c_H_SYNC1 = 10'd751;
   localparam logic [9:0] c_H_LAST  = 10'd799;
   localparam logic [9:0] c_V_VIS   = 10'd480;
   localparam logic [9:0] c_V_SYNC0 = 10'd490;
   localparam logic [9:0] c_V_SYNC1 = 10'd491;
   localparam logic [9:0] c_V_LAST  = 10'd524;

   logic [2:0] mem_q [0:19199];
   logic [2:0] rd_q;

   logic       pix_en_q;
   logic [9:0] hcnt_q, vcnt_q;
   logic       vis_q, hs_q, vs_q;

   // Row-major address y*160 + x, built from shifts.
   logic [14:0] wr_addr, rd_addr;
   logic        wr_ok, vis;

   assign wr_ok   = plot && (x < 8'd160) && (y < 7'd120);
   assign wr_addr = {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
   assign vis     = (hcnt_q < c_H_VIS) && (vcnt_q < c_V_VIS);
   assign rd_addr = vis ? ({1'b0, vcnt_q[8:2], 7'b0} + {3'b0, vcnt_q[8:2], 5'b0} +
                           {7'b0, hcnt_q[9:2]})
                        : 15'd0;

   always_ff @(posedge clock) begin
      if (wr_ok) begin
         mem_q[wr_addr] <= colour;
      end
      rd_q <= mem_q[rd_addr];
   end

   // Timing counters advance on every other clock; sync/blank are delayed one
   // clock to line up with the registered memory read.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pix_en_q <= 1'b0;
         hcnt_q   <= 10'd0;
         vcnt_q   <= 10'd0;
         vis_q    <= 1'b0;
         hs_q     <= 1'b1;
         vs_q     <= 1'b1;
      end else begin
         pix_en_q <= ~pix_en_q;
         vis_q    <= vis;
         hs_q     <= ~((hcnt_q >= c_H_SYNC0) && (hcnt_q <= c_H_SYNC1));
         vs_q     <= ~((vcnt_q >= c_V_SYNC0) && (vcnt_q <= c_V_SYNC1));
         if (pix_en_q) begin
            if (hcnt_q == c_H_LAST) begin
               hcnt_q <= 10'd0;
               vcnt_q <= (vcnt_q == c_V_LAST) ? 10'd0 : vcnt_q + 10'd1;
            end else begin
               hcnt_q <= hcnt_q + 10'd1;
            end
         end
      end
   end

   assign VGA_R   = vis_q ? {8{rd_q[2]}} : 8'd0;
   assign VGA_G   = vis_q ? {8{rd_q[1]}} : 8'd0;
   assign VGA_B   = vis_q ? {8{rd_q[0]}} : 8'd0;
   assign VGA_HS  = hs_q;
   assign VGA_VS  = vs_q;
   assign VGA_CLK = pix_en_q;

endmodule
`default_nettype wire

// File: tb/tb_task3_circle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_task3_circle
//  Description : Scoreboard bench for task3_circle. Expected plot strobes
//                (position, colour, cycle after reset release) are queued
//                from a reference model; a monitor compares every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_task3_circle;

   typedef struct {
      int x;
      int y;
      int c;
      int cyc;
   } pix_t;

   logic       CLOCK_50;
   logic [3:0] KEY;
   logic [9:0] SW;
   logic [9:0] LEDR;
   logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
   logic [7:0] VGA_R, VGA_G, VGA_B;
   logic       VGA_HS, VGA_VS, VGA_CLK;
   logic [7:0] VGA_X;
   logic [6:0] VGA_Y;
   logic [2:0] VGA_COLOUR;
   logic       VGA_PLOT;

   task3_circle dut (
      .CLOCK_50   (CLOCK_50),
      .KEY        (KEY),
      .SW         (SW),
      .LEDR       (LEDR),
      .HEX0       (HEX0),
      .HEX1       (HEX1),
      .HEX2       (HEX2),
      .HEX3       (HEX3),
      .HEX4       (HEX4),
      .HEX5       (HEX5),
      .VGA_R      (VGA_R),
      .VGA_G      (VGA_G),
      .VGA_B      (VGA_B),
      .VGA_HS     (VGA_HS),
      .VGA_VS     (VGA_VS),
      .VGA_CLK    (VGA_CLK),
      .VGA_X      (VGA_X),
      .VGA_Y      (VGA_Y),
      .VGA_COLOUR (VGA_COLOUR),
      .VGA_PLOT   (VGA_PLOT)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   int   n_tests = 0;
   int   n_fail  = 0;
   pix_t exp_q[$];
   pix_t circ[$];
   int   niter;
   int   done_edge;
   int   circ_strobes = 0;

   task automatic chk(input string name, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, got, want);
      end
   endtask

   // Midpoint circle in plain integer arithmetic; cycle numbers count edges
   // after reset release (fill uses edges 0..19199, init 19200).
   function automatic void build_circle();
      int ox, oy, crit;
      int px[8];
      int py[8];
      pix_t p;
      ox = 40; oy = 0; crit = 1 - 40;
      niter = 0;
      circ.delete();
      while (oy <= ox) begin
         px = '{80 + ox, 80 + oy, 80 - ox, 80 - oy, 80 - ox, 80 - oy, 80 + ox, 80 + oy};
         py = '{60 + oy, 60 + ox, 60 + oy, 60 + ox, 60 - oy, 60 - ox, 60 - oy, 60 - ox};
         for (int k = 0; k < 8; k++) begin
            if (px[k] >= 0 && px[k] <= 159 && py[k] >= 0 && py[k] <= 119) begin
               p.x = px[k]; p.y = py[k]; p.c = 2; p.cyc = 19201 + 9 * niter + k;
               circ.push_back(p);
            end
         end
         niter++;
         oy++;
         if (crit <= 0) crit += 2 * oy + 1;
         else begin
            ox--;
            crit += 2 * (oy - ox) + 1;
         end
      end
      done_edge = 19200 + 9 * niter;
   endfunction

   task automatic push_expected();
      pix_t p;
      exp_q.delete();
      for (int i = 0; i < 19200; i++) begin
         p.x = i / 120; p.y = i % 120; p.c = 0; p.cyc = i;
         exp_q.push_back(p);
      end
      foreach (circ[i]) exp_q.push_back(circ[i]);
   endtask

   task automatic run_cycles(input int n);
      repeat (n) begin
         @(negedge CLOCK_50);
         #2;
         SW       = 10'($urandom);
         KEY[2:0] = 3'($urandom);
      end
   endtask

   task automatic release_reset();
      @(negedge CLOCK_50);
      #2;
      push_expected();
      KEY[3] = 1'b1;
   endtask

   task automatic assert_reset();
      @(negedge CLOCK_50);
      #2;
      KEY[3] = 1'b0;
      #1;
      chk("reset_plot_immediate", int'(VGA_PLOT), 0);
      chk("reset_ledr_immediate", int'(LEDR), 0);
      chk("reset_x_immediate", int'(VGA_X), 0);
      chk("reset_y_immediate", int'(VGA_Y), 0);
      chk("reset_colour_immediate", int'(VGA_COLOUR), 0);
      exp_q.delete();
   endtask

   // Monitor: samples on the falling edge, cyc = index of the preceding
   // rising edge counted from reset release.
   initial begin : monitor
      int   cyc;
      pix_t e;
      int   dx, dy;
      cyc = 0;
      forever begin
         @(negedge CLOCK_50);
         if (KEY[3] !== 1'b1) begin
            cyc = 0;
            circ_strobes = 0;
            chk("rst_plot", int'(VGA_PLOT), 0);
            chk("rst_ledr", int'(LEDR), 0);
         end else begin
            chk("hex0", int'(HEX0), 'h7F);
            chk("hex5", int'(HEX5), 'h7F);
            chk("ledr_hi", int'(LEDR[9:1]), 0);
            chk("done_led", int'(LEDR[0]), (cyc >= done_edge) ? 1 : 0);
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
               e = exp_q.pop_front();
               chk("plot", int'(VGA_PLOT), 1);
               chk("x", int'(VGA_X), e.x);
               chk("y", int'(VGA_Y), e.y);
               chk("colour", int'(VGA_COLOUR), e.c);
               if (e.c == 2) begin
                  dx = int'(VGA_X) - 80;
                  dy = int'(VGA_Y) - 60;
                  chk("radius_band", ((dx * dx + dy * dy >= 1521) &&
                                      (dx * dx + dy * dy <= 1681) &&
                                      dx >= -40 && dx <= 40 && dy >= -40 && dy <= 40) ? 1 : 0, 1);
               end
            end else begin
               chk("no_plot", int'(VGA_PLOT), 0);
            end
            if (VGA_PLOT === 1'b1 && VGA_COLOUR == 3'd2) circ_strobes++;
            cyc++;
         end
      end
   end

   initial begin : stimulus
      KEY = 4'hF;
      SW  = 10'd0;
      build_circle();
      #1;
      KEY[3] = 1'b0;
      run_cycles(3);

      // Run 1: reset somewhere in the fill.
      release_reset();
      run_cycles($urandom_range(50, 3000));
      assert_reset();
      run_cycles($urandom_range(1, 3));

      // Run 2: reset somewhere in the circle phase.
      release_reset();
      run_cycles(19201 + $urandom_range(0, 255));
      assert_reset();
      run_cycles($urandom_range(1, 3));

      // Run 3: complete drawing, then hold in DONE.
      release_reset();
      run_cycles(done_edge + 1200);
      chk("queue_drained", exp_q.size(), 0);
      chk("circle_strobes", circ_strobes, 232);
      chk("final_done", int'(LEDR[0]), 1);
      chk("final_plot", int'(VGA_PLOT), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/task3_circle.md
# task3_circle

Top-level block for the circle-drawing stage of the VGA design on the DE1-SoC board. After reset it clears the 160×120 frame buffer to black, one pixel per clock, then draws a green circle of radius 40 centred at (80,60) using the integer midpoint (Bresenham) circle algorithm, one octant pixel per clock. Pixels are written through the team's standard `vga_adapter` core, which it instantiates. The plot bus is also exported so a bench can observe every write directly.

## Interface
- No parameters. Centre (80,60), radius 40 and colour 3'b010 (green) are fixed constants.
- CLOCK_50  in  1  system clock, 50 MHz; all state on its rising edge
- KEY  in  4  KEY[3] is `resetn`: asynchronous, active-low reset. KEY[2:0] unused.
- SW  in  10  unused
- LEDR  out  10  LEDR[0] = done; LEDR[9:1] = 0
- HEX0..HEX5  out  7 each  constant 7'h7F (all segments off)
- VGA_R, VGA_G, VGA_B  out  8 each  from `vga_adapter`
- VGA_HS, VGA_VS, VGA_CLK  out  1 each  from `vga_adapter`
- VGA_X  out  8  plot x, 0..159
- VGA_Y  out  7  plot y, 0..119
- VGA_COLOUR  out  3  plot colour
- VGA_PLOT  out  1  write strobe; one pixel written per cycle where high

## Operation
- VGA_X, VGA_Y, VGA_COLOUR and VGA_PLOT are registered. The same signals feed `vga_adapter` (x, y, colour, plot; resetn = KEY[3]).
- FSM states: FILL, CIRC_INIT, CIRC_PLOT, CIRC_STEP, DONE.
- **FILL**
  - Scans x outer 0..159, y inner 0..119, with colour 0 and PLOT=1.
  - Pixel (x,y) is issued on the fill cycle x·120+y, so 19200 cycles in total.
  - After (159,119) it goes to CIRC_INIT.
- **CIRC_INIT** (1 cycle, PLOT=0)
  - ox=40, oy=0, crit=1−40=−39, octant=0.
- **CIRC_PLOT** (8 cycles, octant 0..7, colour 3'b010). Candidate pixel per octant:
  - 0: (80+ox, 60+oy)
  - 1: (80+oy, 60+ox)
  - 2: (80−ox, 60+oy)
  - 3: (80−oy, 60+ox)
  - 4: (80−ox, 60−oy)
  - 5: (80−oy, 60−ox)
  - 6: (80+ox, 60−oy)
  - 7: (80+oy, 60−ox)
  - Clipping: if the candidate has x∉[0,159] or y∉[0,119], PLOT=0 for that cycle; the cycle is still consumed. No clipping occurs for these constants, but the logic must exist.
  - Duplicate pixels (e.g. at oy=0 or ox=oy) are plotted again, not suppressed.
- **CIRC_STEP** (1 cycle, PLOT=0), in this order:
  - oy ← oy+1.
  - If crit ≤ 0: crit ← crit + 2·(oy+1) + 1.
  - Otherwise: ox ← ox−1, crit ← crit + 2·((oy+1)−(ox−1)) + 1.
  - If the new oy ≤ new ox, return to CIRC_PLOT with octant=0; else go to DONE.
- **DONE**: PLOT=0, LEDR[0]=1. The block holds here until reset.
- Arithmetic: ox, oy and coordinate sums are signed 10-bit; crit is signed 12-bit. Comparisons are signed. The truncation to VGA_X[7:0] / VGA_Y[6:0] happens only after the clip check.

## Timing
- Reset asserted (KEY[3]=0), at any time including mid-fill or mid-circle:
  - Outputs go immediately to VGA_X=0, VGA_Y=0, VGA_COLOUR=0, VGA_PLOT=0, LEDR=0.
  - State goes to FILL with scan counters at 0.
  - `vga_adapter` is reset too.
- First rising edge after release: outputs (0,0), colour 0, PLOT=1.
- Fill takes 19200 cycles, CIRC_INIT 1 cycle, then 9 cycles per circle iteration (8 plot + 1 step).
  - For r=40 there are 29 iterations (oy=0..28).
  - That is 232 plotted cycles; LEDR[0] rises about 19462 cycles after reset release.
- No handshake. `vga_adapter` accepts one write per clock unconditionally.

## Test plan
- Reset then release KEY[3]: the first 19200 cycles have PLOT=1, COLOUR=0, with (X,Y) walking (0,0),(0,1)…(0,119),(1,0)…(159,119).
- First circle iteration: PLOT=1, COLOUR=2 at (120,60),(80,100),(40,60),(80,100),(40,60),(80,20),(120,60),(80,20). Next cycle PLOT=0.
- Second iteration (ox=40, oy=1, crit=−36): the first pixel is (120,61).
- Count circle plots: exactly 232 strobes, all colour 2. Every pixel satisfies |dx|,|dy| ≤ 40 and lies within ±1 of radius 40 (dx²+dy² ∈ [1521,1681]). Last iteration has ox=29 or 28 and oy=28.
- DONE: LEDR[0]=1 and PLOT stays 0 for ≥1000 further cycles; HEX0..5 = 7'h7F throughout.
- Assert KEY[3]=0 mid-circle: PLOT=0 and LEDR[0]=0 immediately. After release the fill restarts from (0,0).
